icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Parametrised instruction-cache miss/refill controller; sits between the I-cache tag/data arrays and the bus interface unit (BIU).
- On a miss it runs an incrementing Wishbone burst of line_beats = LINE_WIDTH/BUS_WIDTH beats and assembles the beats into a line buffer.
- It then writes the full line into the data array in one cycle and pulses a translation-request strobe.
- Compared with the fixed 256-bit/8-beat controller, it adds configurable geometry, bus-error retry, flush abort and freeze-safe strobing.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- LINE_WIDTH, 256, cache line width in bits; must be a power of two and ≥ BUS_WIDTH.
- BUS_WIDTH, 32, BIU data width in bits; power of two, ≥ 8.
- MAX_RETRY, 2, number of burst restarts allowed after wb_err_i before the refill is reported failed.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset: synchronous, active-low.
- freeze, input, 1, pipeline freeze; holds the FSM.
- flush, input, 1, abort any refill in progress.
- req_valid, input, 1, fetch access this cycle.
- req_hit, input, 1, tag hit for the current access.
- req_addr, input, ADDR_WIDTH, fetch physical address.
- biu_cyc_o, output, 1, bus cycle.
- biu_stb_o, output, 1, bus strobe.
- biu_cab_o, output, 1, consecutive-address burst.
- biu_sel_o, output, BUS_WIDTH/8, byte selects.
- biu_adr_o, output, ADDR_WIDTH, beat address.
- wb_dat_i, input, BUS_WIDTH, read data.
- wb_ack_i, input, 1, beat acknowledge.
- wb_err_i, input, 1, bus error.
- line_we, output, 1, data-array line write enable.
- line_addr, output, ADDR_WIDTH, line-aligned write address.
- line_data, output, LINE_WIDTH, assembled line.
- stall, output, 1, stall the fetch stage.
- refill_done, output, 1, one-cycle pulse on completion (translation request).
- refill_err, output, 1, one-cycle pulse on unrecoverable error.

Behaviour:
- Constants:
  - line_beats = LINE_WIDTH/BUS_WIDTH.
  - beat_idx width = clog2(line_beats), minimum 1 bit.
  - Byte offset bits = clog2(LINE_WIDTH/8).
- States: IDLE, BURST, WRITE, DONE, FAIL.
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; beat_idx = 0; retry_cnt = 0; line buffer = 0.
  - All outputs 0.
- freeze = 1:
  - No state, beat, retry or buffer update.
  - biu_stb_o forced 0; biu_cyc_o held.
  - wb_ack_i and wb_err_i are ignored whenever biu_stb_o = 0.
- IDLE:
  - stall = req_valid & ~req_hit.
  - On req_valid & ~req_hit & ~freeze & ~flush: latch base = req_addr with byte-offset bits cleared; beat_idx = 0; retry_cnt = 0; go to BURST.
- BURST outputs:
  - biu_cyc_o = 1; biu_stb_o = ~freeze; biu_cab_o = 1; biu_sel_o = all ones.
  - biu_adr_o = base + beat_idx*(BUS_WIDTH/8).
  - stall = 1.
- BURST transitions, in priority order:
  - flush: go to IDLE next cycle. No line write, no pulse.
  - wb_err_i with retry_cnt < MAX_RETRY: retry_cnt++, beat_idx = 0, stay in BURST.
  - wb_err_i with retry_cnt = MAX_RETRY: go to FAIL.
  - wb_ack_i: buffer slice [beat_idx] = wb_dat_i (beat 0 maps to bits BUS_WIDTH-1:0). On the last beat go to WRITE; otherwise beat_idx++.
  - If ack and err arrive together, err wins and the beat is discarded.
- WRITE (one cycle):
  - line_we = 1; line_addr = base; line_data = buffer; bus outputs 0; stall = 1.
  - Go to DONE. flush is ignored here, because the line is complete.
- DONE (one cycle): refill_done = 1; stall = 1; go to IDLE.
  - The fetch re-looks-up and hits on the following cycle.
- FAIL (one cycle): refill_err = 1; stall = 0; go to IDLE. No line write.
- Latency: minimum miss-to-line_we is 1 + line_beats cycles with zero-wait-state acks.
- line_data and line_addr hold their last values outside WRITE; consumers qualify them with line_we.
- rst_n low mid-burst: drop biu_cyc_o at that edge. Late acks are ignored in IDLE.

Decomposition:
- Package icache_pkg holds:
  - state encoding localparams (IDLE/BURST/WRITE/DONE/FAIL);
  - the clog2 function;
  - default LINE_WIDTH/BUS_WIDTH.
- One sub-module, refill_line_buf: parametrised line buffer with beat-indexed write and a full-line read.

Test Plan:
- Default params, miss at 0x0000_1234, acks every cycle, data = beat number:
  - biu_adr_o steps through 0x1220, 0x1224 … 0x123C;
  - line_we rises at cycle 9 with line_addr = 0x1220 and line_data = {7,6,5,4,3,2,1,0};
  - refill_done pulses at cycle 10.
- Same miss with wait states (ack every 3rd cycle) and freeze held high for 4 cycles mid-burst:
  - biu_stb_o is low during the freeze;
  - no beat is lost or duplicated; line_data is correct.
- wb_err_i on beat 5 once:
  - burst restarts at 0x1220 with retry_cnt = 1;
  - the completed line is correct; refill_err stays 0.
- wb_err_i on every attempt with MAX_RETRY = 2:
  - three bursts run, then refill_err pulses;
  - line_we never asserts; stall drops the same cycle.
- flush asserted on beat 3: next cycle state = IDLE and biu_cyc_o = 0, with no line_we and no refill_done.
- LINE_WIDTH = 512, BUS_WIDTH = 64, miss at 0x0000_0FC8:
  - 8 beats from 0x0FC0 in steps of 8;
  - biu_sel_o = 0xFF; line_we at cycle 9.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants for the I-cache refill controller.
//   - FSM state encoding (plain localparams so older tools and netlists
//     see fixed codes)
//   - clog2 helpers usable in constant expressions
//   - default geometry (256-bit lines over a 32-bit BIU)
package icache_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_LINE_WIDTH = 256;
   localparam int DEF_BUS_WIDTH  = 32;
   localparam int DEF_MAX_RETRY  = 2;

   localparam int         ST_W     = 3;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_BURST = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_FAIL  = 3'd4;

   // ceil(log2(value)); 0 for value <= 1
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // index width that never collapses to zero bits
   function automatic int clog2_min1(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/icache_refill_ctrl_line_buf.sv
// refill_line_buf: line assembly buffer for the refill controller.
//   clk, rst_n : clock, synchronous active-low reset (clears the buffer)
//   wr_en      : write one beat this cycle
//   wr_idx     : beat slot to write (slot 0 = bits BUS_WIDTH-1:0)
//   wr_data    : beat data
//   line_o     : full line, including the beat being written this cycle,
//                so the last beat can be committed in the same cycle it
//                arrives without waiting for the buffer to settle
module refill_line_buf
   import icache_pkg::*;
#(
   parameter int LINE_WIDTH = DEF_LINE_WIDTH,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int IDX_W      = clog2_min1(DEF_LINE_WIDTH / DEF_BUS_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [BUS_WIDTH-1:0]  wr_data,
   output logic [LINE_WIDTH-1:0] line_o
);

   localparam int NUM_BEATS = LINE_WIDTH / BUS_WIDTH;

   logic [NUM_BEATS-1:0][BUS_WIDTH-1:0] line_q, line_d;

   always_comb begin
      line_d = line_q;
      for (int b = 0; b < NUM_BEATS; b++) begin
         if (wr_en && (wr_idx == IDX_W'(b))) line_d[b] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) line_q <= '0;
      else        line_q <= line_d;
   end

   assign line_o = line_d;

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: I-cache miss/refill controller.
// On a fetch miss it runs an incrementing Wishbone burst of
// LINE_WIDTH/BUS_WIDTH beats, assembles them into a line, writes the line
// into the data array in one cycle and then pulses refill_done.
//   clk, rst_n        : clock, synchronous active-low reset
//   freeze            : pipeline freeze; FSM, counters and buffer hold
//   flush             : abort a refill still in its burst
//   req_valid/hit/addr: fetch access, tag result, physical address
//   biu_*             : Wishbone master side (cyc/stb/cab/sel/adr)
//   wb_dat_i/ack/err  : Wishbone read data and handshake
//   line_we/addr/data : data-array line write (qualify with line_we)
//   stall             : stall the fetch stage
//   refill_done/err   : completion / unrecoverable-error pulses
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LINE_WIDTH = DEF_LINE_WIDTH,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   freeze,
   input  logic                   flush,
   input  logic                   req_valid,
   input  logic                   req_hit,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   output logic                   biu_cyc_o,
   output logic                   biu_stb_o,
   output logic                   biu_cab_o,
   output logic [BUS_WIDTH/8-1:0] biu_sel_o,
   output logic [ADDR_WIDTH-1:0]  biu_adr_o,
   input  logic [BUS_WIDTH-1:0]   wb_dat_i,
   input  logic                   wb_ack_i,
   input  logic                   wb_err_i,
   output logic                   line_we,
   output logic [ADDR_WIDTH-1:0]  line_addr,
   output logic [LINE_WIDTH-1:0]  line_data,
   output logic                   stall,
   output logic                   refill_done,
   output logic                   refill_err
);

   localparam int LINE_BEATS = LINE_WIDTH / BUS_WIDTH;
   localparam int IDX_W      = clog2_min1(LINE_BEATS);
   localparam int OFF_BITS   = clog2(LINE_WIDTH / 8);
   localparam int BEAT_SH    = clog2(BUS_WIDTH / 8);
   localparam int RTY_W      = clog2_min1(MAX_RETRY + 1);

   localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
   localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(LINE_BEATS - 1);
   localparam logic [RTY_W-1:0]      RETRY_MAX = RTY_W'(MAX_RETRY);

   logic [ST_W-1:0]       state_q, state_d;
   logic [IDX_W-1:0]      beat_q, beat_d;
   logic [RTY_W-1:0]      retry_q, retry_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
   logic [LINE_WIDTH-1:0] line_data_q, line_data_d;

   logic                  buf_we;
   logic [LINE_WIDTH-1:0] buf_line;
   logic [ADDR_WIDTH-1:0] beat_off;

   refill_line_buf #(
      .LINE_WIDTH (LINE_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH),
      .IDX_W      (IDX_W)
   ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (buf_we),
      .wr_idx  (beat_q),
      .wr_data (wb_dat_i),
      .line_o  (buf_line)
   );

   assign beat_off = ADDR_WIDTH'(beat_q) << BEAT_SH;

   // Next-state logic. freeze gates everything: stb is low while frozen,
   // so ack/err seen during a freeze are never consumed.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      retry_d     = retry_q;
      base_d      = base_q;
      line_addr_d = line_addr_q;
      line_data_d = line_data_q;
      buf_we      = 1'b0;
      if (!freeze) begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && !req_hit && !flush) begin
                  base_d  = req_addr & ~OFF_MASK;
                  beat_d  = '0;
                  retry_d = '0;
                  state_d = ST_BURST;
               end
            end
            ST_BURST: begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else if (wb_err_i) begin
                  // err beats a simultaneous ack; that beat is dropped
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + 1'b1;
                     beat_d  = '0;
                  end else begin
                     state_d = ST_FAIL;
                  end
               end else if (wb_ack_i) begin
                  buf_we = 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     // capture the completed line (bypass includes this
                     // beat) so line_data holds until the next WRITE
                     line_data_d = buf_line;
                     line_addr_d = base_q;
                     state_d     = ST_WRITE;
                  end else begin
                     beat_d = beat_q + 1'b1;
                  end
               end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         retry_q     <= '0;
         base_q      <= '0;
         line_addr_q <= '0;
         line_data_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         retry_q     <= retry_d;
         base_q      <= base_d;
         line_addr_q <= line_addr_d;
         line_data_q <= line_data_d;
      end
   end

   // Outputs. Strobes in WRITE/DONE/FAIL are masked by freeze so a frozen
   // FSM cannot stretch a one-cycle pulse; the pulse fires on the cycle
   // the state actually advances.
   always_comb begin
      biu_cyc_o   = 1'b0;
      biu_stb_o   = 1'b0;
      biu_cab_o   = 1'b0;
      biu_sel_o   = '0;
      biu_adr_o   = '0;
      stall       = 1'b0;
      line_we     = 1'b0;
      refill_done = 1'b0;
      refill_err  = 1'b0;
      case (state_q)
         ST_IDLE:  stall = req_valid & ~req_hit;
         ST_BURST: begin
            biu_cyc_o = 1'b1;
            biu_stb_o = ~freeze;
            biu_cab_o = 1'b1;
            biu_sel_o = '1;
            biu_adr_o = base_q + beat_off;
            stall     = 1'b1;
         end
         ST_WRITE: begin
            line_we = ~freeze;
            stall   = 1'b1;
         end
         ST_DONE: begin
            refill_done = ~freeze;
            stall       = 1'b1;
         end
         ST_FAIL:  refill_err = ~freeze;
         default:  ;
      endcase
   end

   assign line_addr = line_addr_q;
   assign line_data = line_data_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-geometry DUT
   logic         rst_n, freeze, flush, req_valid, req_hit;
   logic [31:0]  req_addr;
   logic         biu_cyc_o, biu_stb_o, biu_cab_o;
   logic [3:0]   biu_sel_o;
   logic [31:0]  biu_adr_o, wb_dat_i;
   logic         wb_ack_i, wb_err_i, line_we, stall, refill_done, refill_err;
   logic [31:0]  line_addr;
   logic [255:0] line_data;

   // wide-geometry DUT (512-bit line, 64-bit bus)
   logic         w_freeze, w_flush, w_req_valid, w_req_hit;
   logic [31:0]  w_req_addr;
   logic         w_cyc, w_stb, w_cab;
   logic [7:0]   w_sel;
   logic [31:0]  w_adr;
   logic [63:0]  w_dat;
   logic         w_ack, w_err, w_line_we, w_stall, w_done, w_rerr;
   logic [31:0]  w_line_addr;
   logic [511:0] w_line_data;

   icache_refill_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
      .req_valid(req_valid), .req_hit(req_hit), .req_addr(req_addr),
      .biu_cyc_o(biu_cyc_o), .biu_stb_o(biu_stb_o), .biu_cab_o(biu_cab_o),
      .biu_sel_o(biu_sel_o), .biu_adr_o(biu_adr_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .line_we(line_we),
      .line_addr(line_addr), .line_data(line_data), .stall(stall),
      .refill_done(refill_done), .refill_err(refill_err)
   );

   icache_refill_ctrl #(.ADDR_WIDTH(32), .LINE_WIDTH(512), .BUS_WIDTH(64), .MAX_RETRY(2)) u_dutw (
      .clk(clk), .rst_n(rst_n), .freeze(w_freeze), .flush(w_flush),
      .req_valid(w_req_valid), .req_hit(w_req_hit), .req_addr(w_req_addr),
      .biu_cyc_o(w_cyc), .biu_stb_o(w_stb), .biu_cab_o(w_cab),
      .biu_sel_o(w_sel), .biu_adr_o(w_adr), .wb_dat_i(w_dat),
      .wb_ack_i(w_ack), .wb_err_i(w_err), .line_we(w_line_we),
      .line_addr(w_line_addr), .line_data(w_line_data), .stall(w_stall),
      .refill_done(w_done), .refill_err(w_rerr)
   );

   int errors = 0;
   int checks = 0;

   // bus slave plan and observation record
   int           cur, ack_period, wait_cnt, err_beat, err_left, flush_beat, flush_cyc;
   int           frz_from, frz_len, attempt_beat, bursts, stb_frz, cyc_frz_low, bus_bad;
   int           we_cnt, we_cyc, done_cnt, done_cyc, err_cnt, err_cyc, dat_mode;
   logic         err_stall, cyc_after_flush, stall0, timeout;
   logic [31:0]  we_addr, salt;
   logic [255:0] we_data;
   logic [31:0]  acked[$];

   // memory contents seen by the slave: beat number, or a salted hash
   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (dat_mode == 0) return (a >> 2) & 32'd7;
      return salt ^ (a * 32'h9E3779B1);
   endfunction

   function automatic logic [255:0] exp_line(input logic [31:0] base);
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = data_of(base + 32'(k * 4));
      return r;
   endfunction

   function automatic logic [63:0] wdata_of(input logic [31:0] a);
      return {salt ^ a, a * 32'h01000193};
   endfunction

   task automatic prep(input int ap, input int eb, input int el, input int fb,
                       input int ff, input int fl);
      ack_period = ap; err_beat = eb; err_left = el; flush_beat = fb;
      frz_from = ff; frz_len = fl;
      wait_cnt = 0; attempt_beat = 0; bursts = 0; flush_cyc = -10;
      stb_frz = 0; cyc_frz_low = 0; bus_bad = 0;
      we_cnt = 0; we_cyc = -1; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
      err_stall = 1'bx; cyc_after_flush = 1'bx; stall0 = 1'bx; timeout = 1'b0;
      we_addr = '0; we_data = '0;
      acked.delete();
   endtask

   // one clock of the default DUT; entered just after a negedge
   task automatic cycle();
      freeze = (cur >= frz_from) && (cur < frz_from + frz_len);
      flush = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      #1;
      if (cur == 0) stall0 = stall;
      if (freeze && biu_stb_o) stb_frz++;
      if (freeze && !biu_cyc_o && cur > 0 && we_cnt == 0) cyc_frz_low++;
      if (cur == flush_cyc + 1) cyc_after_flush = biu_cyc_o;
      if (biu_stb_o) begin
         if (biu_sel_o !== 4'hF || biu_cab_o !== 1'b1 || biu_cyc_o !== 1'b1) bus_bad++;
         if (attempt_beat == flush_beat && flush_cyc < 0) begin
            flush = 1'b1; flush_cyc = cur;
         end else begin
            wait_cnt++;
            if (wait_cnt >= ack_period) begin
               wait_cnt = 0;
               if (attempt_beat == err_beat && err_left != 0) begin
                  wb_err_i = 1'b1;
                  if (err_left > 0) err_left--;
                  attempt_beat = 0; bursts++;
               end else begin
                  wb_ack_i = 1'b1;
                  wb_dat_i = data_of(biu_adr_o);
                  acked.push_back(biu_adr_o);
                  attempt_beat++;
               end
            end
         end
      end
      #1;
      if (line_we) begin we_cnt++; we_cyc = cur; we_addr = line_addr; we_data = line_data; end
      if (refill_done) begin done_cnt++; done_cyc = cur; end
      if (refill_err) begin err_cnt++; err_cyc = cur; err_stall = stall; end
      @(posedge clk); @(negedge clk);
      cur++;
   endtask

   task automatic run_refill(input logic [31:0] addr, input int budget);
      int n;
      cur = 0;
      req_valid = 1'b1; req_hit = 1'b0; req_addr = addr;
      cycle();
      req_valid = 1'b0; req_addr = $urandom;
      n = 0;
      while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
         cycle(); n++;
         if (flush_cyc >= 0 && cur > flush_cyc + 4) break;
      end
      timeout = (n >= budget);
      cycle(); cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; freeze = 0; flush = 0; req_valid = 0; req_hit = 0; req_addr = 32'h1234;
      wb_dat_i = '1; wb_ack_i = 0; wb_err_i = 0;
      w_freeze = 0; w_flush = 0; w_req_valid = 0; w_req_hit = 0; w_req_addr = '0;
      w_dat = '0; w_ack = 0; w_err = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({biu_cyc_o, biu_stb_o, biu_cab_o, biu_sel_o, biu_adr_o} !== '0) begin
         errors++; $display("FAIL reset_bus: got cyc=%b stb=%b cab=%b sel=%h adr=%h, want all 0",
                            biu_cyc_o, biu_stb_o, biu_cab_o, biu_sel_o, biu_adr_o);
      end
      checks++;
      if ({line_we, line_addr, line_data, stall, refill_done, refill_err} !== '0) begin
         errors++; $display("FAIL reset_line: got we=%b addr=%h stall=%b done=%b err=%b data=%h, want all 0",
                            line_we, line_addr, stall, refill_done, refill_err, line_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_hit();
      req_valid = 1'b1; req_hit = 1'b1; req_addr = 32'h4000;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b want 0", stall); end
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (biu_cyc_o !== 1'b0) begin errors++; $display("FAIL hit_no_burst: cyc got %b want 0", biu_cyc_o); end
      req_valid = 1'b0; req_hit = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      dat_mode = 0;
      prep(1, -1, 0, -1, -100, 0);
      run_refill(32'h0000_1234, 100);
      checks++;
      if (timeout || acked.size() != 8) begin
         errors++; $display("FAIL basic_beats: got %0d beats timeout=%b want 8", acked.size(), timeout);
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (acked[k] !== 32'h1220 + 32'(4 * k)) begin
               errors++; $display("FAIL basic_adr%0d: got %h want %h", k, acked[k], 32'h1220 + 32'(4 * k));
            end
         end
      end
      checks++;
      if (stall0 !== 1'b1) begin errors++; $display("FAIL basic_miss_stall: got %b want 1", stall0); end
      checks++;
      if (bus_bad != 0) begin errors++; $display("FAIL basic_bus_ctl: %0d bad beats want 0", bus_bad); end
      checks++;
      if (we_cyc != 9 || we_cnt != 1) begin
         errors++; $display("FAIL basic_we_cycle: got cycle %0d count %0d want 9/1", we_cyc, we_cnt);
      end
      checks++;
      if (we_addr !== 32'h1220) begin errors++; $display("FAIL basic_line_addr: got %h want 00001220", we_addr); end
      checks++;
      if (we_data !== exp_line(32'h1220)) begin
         errors++; $display("FAIL basic_line_data: got %h want %h", we_data, exp_line(32'h1220));
      end
      checks++;
      if (done_cyc != 10 || done_cnt != 1 || err_cnt != 0) begin
         errors++; $display("FAIL basic_done: got cycle %0d count %0d err %0d want 10/1/0", done_cyc, done_cnt, err_cnt);
      end
   endtask

   task automatic test_wait_freeze();
      dat_mode = 1; salt = $urandom;
      prep(3, -1, 0, -1, 7, 4);
      run_refill(32'h0000_1234, 200);
      checks++;
      if (stb_frz != 0 || cyc_frz_low != 0) begin
         errors++; $display("FAIL freeze_bus: stb-high %0d cyc-low %0d cycles during freeze want 0/0", stb_frz, cyc_frz_low);
      end
      checks++;
      if (timeout || acked.size() != 8) begin
         errors++; $display("FAIL freeze_beats: got %0d beats timeout=%b want 8", acked.size(), timeout);
      end
      checks++;
      if (we_data !== exp_line(32'h1220) || we_cnt != 1 || done_cnt != 1) begin
         errors++; $display("FAIL freeze_line: got %h we=%0d done=%0d want %h 1/1", we_data, we_cnt, done_cnt, exp_line(32'h1220));
      end
   endtask

   task automatic test_err_once();
      dat_mode = 1; salt = $urandom;
      prep(1, 5, 1, -1, -100, 0);
      run_refill(32'h0000_1234, 100);
      checks++;
      if (bursts != 1 || acked.size() != 13) begin
         errors++; $display("FAIL err1_beats: got errs=%0d beats=%0d want 1/13", bursts, acked.size());
      end else begin
         checks++;
         if (acked[5] !== 32'h1220) begin errors++; $display("FAIL err1_restart: got %h want 00001220", acked[5]); end
      end
      checks++;
      if (we_data !== exp_line(32'h1220) || we_cyc != 15) begin
         errors++; $display("FAIL err1_line: got %h at %0d want %h at 15", we_data, we_cyc, exp_line(32'h1220));
      end
      checks++;
      if (err_cnt != 0 || done_cnt != 1) begin
         errors++; $display("FAIL err1_pulses: got err=%0d done=%0d want 0/1", err_cnt, done_cnt);
      end
   endtask

   task automatic test_err_always();
      dat_mode = 1; salt = $urandom;
      prep(1, 2, -1, -1, -100, 0);
      run_refill(32'h0000_1234, 100);
      checks++;
      if (bursts != 3 || err_cnt != 1 || err_cyc != 10) begin
         errors++; $display("FAIL errN_fail: got bursts=%0d err=%0d at %0d want 3/1 at 10", bursts, err_cnt, err_cyc);
      end
      checks++;
      if (we_cnt != 0 || done_cnt != 0) begin
         errors++; $display("FAIL errN_no_write: got we=%0d done=%0d want 0/0", we_cnt, done_cnt);
      end
      checks++;
      if (err_stall !== 1'b0) begin errors++; $display("FAIL errN_stall: got %b want 0", err_stall); end
   endtask

   task automatic test_flush();
      dat_mode = 1; salt = $urandom;
      prep(1, -1, 0, 3, -100, 0);
      run_refill(32'h0000_1234, 100);
      checks++;
      if (flush_cyc != 4 || cyc_after_flush !== 1'b0) begin
         errors++; $display("FAIL flush_abort: flush at %0d cyc after=%b want 4/0", flush_cyc, cyc_after_flush);
      end
      checks++;
      if (we_cnt != 0 || done_cnt != 0 || err_cnt != 0 || acked.size() != 3) begin
         errors++; $display("FAIL flush_quiet: got we=%0d done=%0d err=%0d beats=%0d want 0/0/0/3",
                            we_cnt, done_cnt, err_cnt, acked.size());
      end
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 6; it++) begin
         logic [31:0] addr, base;
         int ap, eb, el;
         dat_mode = 1; salt = $urandom;
         ap = $urandom_range(1, 3); eb = $urandom_range(0, 7); el = $urandom_range(0, 1);
         addr = $urandom; base = addr & ~32'h1F;
         prep(ap, eb, el, -1, -100, 0);
         run_refill(addr, 300);
         checks++;
         if (timeout || we_cnt != 1 || done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL rnd%0d_flow: timeout=%b we=%0d done=%0d err=%0d want 0/1/1/0",
                               it, timeout, we_cnt, done_cnt, err_cnt);
         end
         checks++;
         if (we_addr !== base) begin errors++; $display("FAIL rnd%0d_addr: got %h want %h", it, we_addr, base); end
         checks++;
         if (we_data !== exp_line(base)) begin
            errors++; $display("FAIL rnd%0d_data: got %h want %h", it, we_data, exp_line(base));
         end
         checks++;
         if (acked.size() != 8 + (el != 0 ? eb : 0)) begin
            errors++; $display("FAIL rnd%0d_beats: got %0d want %0d", it, acked.size(), 8 + (el != 0 ? eb : 0));
         end
      end
   endtask

   task automatic test_reset_mid();
      dat_mode = 1; salt = $urandom;
      prep(1, -1, 0, -1, -100, 0);
      cur = 0;
      req_valid = 1'b1; req_hit = 1'b0; req_addr = 32'h0000_2000;
      cycle();
      req_valid = 1'b0;
      cycle(); cycle(); cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      wb_ack_i = 1'b1; wb_err_i = 1'b0; wb_dat_i = $urandom;
      #1;
      checks++;
      if (biu_cyc_o !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL rstmid_drop: got cyc=%b stall=%b want 0/0", biu_cyc_o, stall);
      end
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (line_we !== 1'b0 || biu_cyc_o !== 1'b0 || refill_done !== 1'b0) begin
         errors++; $display("FAIL rstmid_late_ack: got we=%b cyc=%b done=%b want 0/0/0", line_we, biu_cyc_o, refill_done);
      end
      wb_ack_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wide();
      logic [31:0]  wq[$];
      logic [511:0] exp;
      int wcyc, sel_bad;
      salt = $urandom; wcyc = -1; sel_bad = 0;
      for (int k = 0; k < 8; k++) exp[k*64 +: 64] = wdata_of(32'h0FC0 + 32'(8 * k));
      for (int c = 0; c < 30; c++) begin
         w_req_valid = (c == 0); w_req_hit = 1'b0; w_req_addr = 32'h0000_0FC8;
         w_ack = 1'b0; w_dat = {$urandom, $urandom};
         #1;
         if (w_stb) begin
            if (w_sel !== 8'hFF) sel_bad++;
            w_ack = 1'b1; w_dat = wdata_of(w_adr); wq.push_back(w_adr);
         end
         #1;
         if (w_line_we) begin
            wcyc = c;
            checks++;
            if (w_line_addr !== 32'h0FC0 || w_line_data !== exp) begin
               errors++; $display("FAIL wide_line: got %h %h want 00000fc0 %h", w_line_addr, w_line_data, exp);
            end
         end
         @(posedge clk); @(negedge clk);
      end
      w_ack = 1'b0; w_req_valid = 1'b0;
      checks++;
      if (wcyc != 9 || sel_bad != 0) begin
         errors++; $display("FAIL wide_timing: line_we at %0d sel_bad=%0d want 9/0", wcyc, sel_bad);
      end
      checks++;
      if (wq.size() != 8) begin
         errors++; $display("FAIL wide_beats: got %0d want 8", wq.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (wq[k] !== 32'h0FC0 + 32'(8 * k)) begin
               errors++; $display("FAIL wide_adr%0d: got %h want %h", k, wq[k], 32'h0FC0 + 32'(8 * k));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hit();
      test_basic();
      test_wait_freeze();
      test_err_once();
      test_err_always();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
